fp8_array_sched: RTL and testbench
==================================

Name: fp8_array_sched

Overview:
- Sequencer for an N x N output-stationary systolic array of FP8 (E4M3) multiply-accumulate PEs.
- Accepts one operand vector pair per k-step over a valid/ready stream and skews it onto the array row/column edges.
- Clears the PE accumulators before each job and waits a fixed drain time.
- Snapshots all N*N 16-bit accumulators, then returns them row-major over a valid/ready result port.

Parameters:
- N, 2, array dimension (rows = columns).
- KW, 8, width of the k_len job-length field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  job request; sampled only in IDLE
- k_len  in  KW  number of k-steps in the job; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result handshake
- in_valid  in  1  operand vector valid
- in_ready  out  1  high only in STREAM
- in_a  in  N*8  A column vector; lane i drives array row i
- in_b  in  N*8  B row vector; lane j drives array column j
- pe_clear  out  1  accumulator clear to every PE
- pe_a  out  N*8  skewed A lanes to the array west edge
- pe_b  out  N*8  skewed B lanes to the array north edge
- pe_c  in  N*N*16  accumulator outputs; PE(r,c) occupies bits [(r*N+c)*16 +: 16]
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  16  signed accumulator value
- res_row  out  $clog2(N)  row index of res_data
- res_col  out  $clog2(N)  column index of res_data
- res_last  out  1  high with the final result of the job

Behaviour:
- Reset (synchronous) drives all of the following:
  - State goes to IDLE.
  - busy, done, in_ready, pe_clear, res_valid and res_last are 0.
  - pe_a, pe_b, res_data, res_row, res_col and all skew registers are 0.
  - A reset mid-job abandons the job; no done pulse is issued.
- States: IDLE -> CLEAR -> STREAM -> DRAIN -> READ -> IDLE.
- IDLE: start=1 latches k_len and moves to CLEAR. start in any other state is ignored.
- CLEAR: pe_clear=1 for exactly one cycle, with pe_a=pe_b=0.
  - Next state is STREAM, or DRAIN directly if k_len=0.
- STREAM:
  - in_ready=1.
  - On each cycle with in_valid & in_ready, the vector enters the skew lines and the step counter increments.
  - On a cycle with in_valid=0, an all-zero vector (0x00 on every lane) enters instead. Zero is an exact additive identity, so wavefront alignment is preserved.
  - After the k_len-th accept, the block moves to DRAIN.
- Skew: lane i of A and lane j of B are delayed i+1 and j+1 registered cycles respectively.
  - All pe_a/pe_b outputs are registered.
  - Zeros are fed whenever the state is not STREAM.
- DRAIN: lasts exactly 2N cycles, which covers skew, PE hop propagation and the accumulator register.
  - On the last DRAIN cycle, all of pe_c is captured into an N*N snapshot register.
  - The next state is READ.
- READ:
  - Results are presented in row-major order (r then c).
  - res_valid=1 holds until res_ready; res_data, res_row, res_col and res_last stay stable while res_valid & !res_ready.
  - res_last=1 on index N*N-1.
  - The handshake on the last result produces done=1 on the next cycle, together with the return to IDLE.
- Throughput:
  - Minimum job latency from start to first res_valid is 1 + k_len + 2N + 1 cycles.
  - A new start is accepted on the done cycle, i.e. in IDLE.
- Arithmetic: no arithmetic on results. Values pass through bit-exact as two's-complement 16-bit (7 fractional bits, 1.0*1.0 = 128).
- k_len=2^KW-1 is legal; the step counter is KW bits and does not wrap before the comparison.

Optional Feature:
- Macro FP8_SCHED_PERF_EN.
- When defined, two extra output ports are added:
  - perf_stall [15:0]: counts STREAM cycles with in_valid=0. Saturates at 0xFFFF and clears on accept of start.
  - perf_jobs [15:0]: counts done pulses. Wraps, and clears only on rst.
- When undefined, neither port nor its counters exist, and behaviour is otherwise identical.

Decomposition:
- Package fp8_tpu_pkg holds:
  - the state enum (IDLE, CLEAR, STREAM, DRAIN, READ);
  - FP8_ZERO = 8'h00 and FP8_ONE = 8'h38;
  - ACC_W = 16.
- Sub-module fp8_skew_line (parameter DEPTH, 8-bit data, sync reset) is instantiated once per lane, 2N instances.

Test Plan:
- N=2, k_len=3, in_a=in_b={0x38,0x38} for all steps, in_valid=1 -> pe_clear high one cycle; 4 results of 0x0180 in order (0,0),(0,1),(1,0),(1,1); res_last on the 4th; done one cycle later.
- k_len=2, A lanes {0x40,0xB8}, B lanes {0x38,0x38} -> row 0 results 0x0200, row 1 results 0xFF00.
- Same as the first scenario, but in_valid deasserted for 5 cycles between steps -> identical results 0x0180; with FP8_SCHED_PERF_EN defined, perf_stall=5.
- k_len=0 -> no in_ready cycles; 4 results of 0x0000; done asserted.
- res_ready held low for 3 cycles on each result -> res_data/res_row/res_col stable while stalled; each result handshakes exactly once.
- rst asserted during DRAIN -> next cycle all outputs at reset values, no done pulse; a subsequent start with k_len=1 and 1.0 operands yields four results of 0x0080.

Source files
------------

// File: rtl/fp8_tpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp8_tpu_pkg: shared types and constants for the FP8 array sequencer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fp8_tpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    READ   = 3'd4
  } sched_state_t;

  localparam logic [7:0] FP8_ZERO = 8'h00;
  localparam logic [7:0] FP8_ONE  = 8'h38;
  localparam int         ACC_W    = 16;

endpackage
`default_nettype wire

// File: rtl/fp8_array_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp8_array_sched_if: operand stream and result stream of the sequencer|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fp8_array_sched_if
  import fp8_tpu_pkg::*;
#(
  parameter int N = 2
);

  logic                 in_valid;
  logic                 in_ready;
  logic [N*8-1:0]       in_a;
  logic [N*8-1:0]       in_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_W-1:0]     res_data;
  logic [$clog2(N)-1:0] res_row;
  logic [$clog2(N)-1:0] res_col;
  logic                 res_last;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_row, res_col, res_last
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_row, res_col, res_last
  );

endinterface
`default_nettype wire

// File: rtl/fp8_skew_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp8_skew_line: DEPTH-stage registered delay for one 8-bit array lane |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp8_skew_line #(
  parameter int DEPTH = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [7:0] i_d,
  output logic      [7:0] o_q
);

  logic [7:0] r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fp8_array_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp8_array_sched: job sequencer for an NxN output-stationary FP8 array|
// | Option FP8_SCHED_PERF_EN adds perf_stall/perf_jobs.      Rev 1.0     |
// +----------------------------------------------------------------------+
module fp8_array_sched
  import fp8_tpu_pkg::*;
#(
  parameter int N  = 2,
  parameter int KW = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 start,
  input  wire logic [KW-1:0]        k_len,
  output logic                      busy,
  output logic                      done,
  output logic                      pe_clear,
  output logic [N*8-1:0]            pe_a,
  output logic [N*8-1:0]            pe_b,
  input  wire logic [N*N*ACC_W-1:0] pe_c,
`ifdef FP8_SCHED_PERF_EN
  output logic [15:0]               perf_stall,
  output logic [15:0]               perf_jobs,
`endif
  fp8_array_sched_if.slave          bus
);

  localparam int c_NRES    = N * N;
  localparam int c_IDX_W   = $clog2(c_NRES);
  localparam int c_RC_W    = $clog2(N);
  localparam int c_DRAIN_W = $clog2(2 * N) + 1;

  sched_state_t         r_state, w_next;
  logic [KW-1:0]        r_klen, r_step;
  logic [c_DRAIN_W-1:0] r_drain;
  logic [c_IDX_W-1:0]   r_idx;
  logic [ACC_W-1:0]     r_snap [c_NRES];
  logic                 r_done;

  logic w_accept, w_res_hs, w_last_step, w_drain_end, w_last_res;
  logic [31:0] w_idx32;

  assign w_accept    = (r_state == STREAM) & bus.in_valid;
  assign w_res_hs    = (r_state == READ) & bus.res_ready;
  assign w_last_step = (r_step == r_klen - KW'(1));
  assign w_drain_end = (r_drain == c_DRAIN_W'(2 * N - 1));
  assign w_last_res  = (r_idx == c_IDX_W'(c_NRES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CLEAR;
      CLEAR:   w_next = (r_klen == '0) ? DRAIN : STREAM;
      STREAM:  if (w_accept && w_last_step) w_next = DRAIN;
      DRAIN:   if (w_drain_end) w_next = READ;
      READ:    if (w_res_hs && w_last_res) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_klen  <= '0;
      r_step  <= '0;
      r_drain <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_res_hs & w_last_res;
      if (r_state == IDLE && start) r_klen <= k_len;
      if (r_state == CLEAR)  r_step <= '0;
      else if (w_accept)     r_step <= r_step + KW'(1);
      if (r_state == DRAIN)  r_drain <= r_drain + c_DRAIN_W'(1);
      else                   r_drain <= '0;
      if (r_state != READ)   r_idx <= '0;
      else if (w_res_hs)     r_idx <= w_last_res ? '0 : r_idx + c_IDX_W'(1);
    end
  end

  // The array result is final only at the end of the last drain cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_NRES; i++) r_snap[i] <= '0;
    end else if (r_state == DRAIN && w_drain_end) begin
      for (int i = 0; i < c_NRES; i++) r_snap[i] <= pe_c[i*ACC_W +: ACC_W];
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [7:0] w_a_in, w_b_in;
      assign w_a_in = w_accept ? bus.in_a[i*8 +: 8] : FP8_ZERO;
      assign w_b_in = w_accept ? bus.in_b[i*8 +: 8] : FP8_ZERO;

      fp8_skew_line #(.DEPTH(i + 1)) u_skew_a (
        .clk (clk),
        .rst (rst),
        .i_d (w_a_in),
        .o_q (pe_a[i*8 +: 8])
      );

      fp8_skew_line #(.DEPTH(i + 1)) u_skew_b (
        .clk (clk),
        .rst (rst),
        .i_d (w_b_in),
        .o_q (pe_b[i*8 +: 8])
      );
    end
  endgenerate

  assign w_idx32       = 32'(r_idx);
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign pe_clear      = (r_state == CLEAR);
  assign bus.in_ready  = (r_state == STREAM);
  assign bus.res_valid = (r_state == READ);
  assign bus.res_data  = (r_state == READ) ? r_snap[r_idx] : '0;
  assign bus.res_row   = (r_state == READ) ? c_RC_W'(w_idx32 / 32'(N)) : '0;
  assign bus.res_col   = (r_state == READ) ? c_RC_W'(w_idx32 % 32'(N)) : '0;
  assign bus.res_last  = (r_state == READ) & w_last_res;

`ifdef FP8_SCHED_PERF_EN
  logic [15:0] r_perf_stall, r_perf_jobs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_jobs  <= '0;
    end else begin
      if (r_state == IDLE && start)
        r_perf_stall <= '0;
      else if (r_state == STREAM && !bus.in_valid && r_perf_stall != 16'hFFFF)
        r_perf_stall <= r_perf_stall + 16'd1;
      if (r_done) r_perf_jobs <= r_perf_jobs + 16'd1;
    end
  end

  assign perf_stall = r_perf_stall;
  assign perf_jobs  = r_perf_jobs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp8_array_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp8_array_sched: FP8 array model plus job-level reference checker |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fp8_array_sched;
  import fp8_tpu_pkg::*;

  localparam int N  = 2;
  localparam int KW = 8;
  localparam int NR = N * N;
  localparam int RW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic [KW-1:0]     k_len;
  logic              busy, done, pe_clear;
  logic [N*8-1:0]    pe_a, pe_b;
  logic [NR*16-1:0]  pe_c;
`ifdef FP8_SCHED_PERF_EN
  logic [15:0]       perf_stall, perf_jobs;
`endif

  fp8_array_sched_if #(.N(N)) bus ();

  fp8_array_sched #(.N(N), .KW(KW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .busy     (busy),
    .done     (done),
    .pe_clear (pe_clear),
    .pe_a     (pe_a),
    .pe_b     (pe_b),
    .pe_c     (pe_c),
`ifdef FP8_SCHED_PERF_EN
    .perf_stall (perf_stall),
    .perf_jobs  (perf_jobs),
`endif
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int stall_cnt = 0;
  int jobs_done = 0;

  logic [N*8-1:0] stim_a[$], stim_b[$];
  logic [N*8-1:0] acc_a[$], acc_b[$];
  logic [15:0]    got [NR];
  logic [7:0]     pool [7];

  // E4M3 value in units of 2^-9 (smallest subnormal).
  function automatic longint fp8_v(input logic [7:0] b);
    longint m;
    int e;
    e = int'(b[6:3]);
    m = (e == 0) ? longint'(b[2:0]) : longint'({1'b1, b[2:0]});
    if (e > 1) m = m <<< (e - 1);
    return b[7] ? -m : m;
  endfunction

  function automatic logic [15:0] mulq(input logic [7:0] a, input logic [7:0] b);
    longint p;
    p = fp8_v(a) * fp8_v(b);
    return 16'(p >>> 11);
  endfunction

  function automatic logic [15:0] ref_c(input int r, input int c);
    logic [15:0] s;
    s = '0;
    foreach (acc_a[j]) s = s + mulq(acc_a[j][r*8 +: 8], acc_b[j][c*8 +: 8]);
    return s;
  endfunction

  // Output-stationary array: A moves east, B moves south, one register per hop.
  logic [15:0] acc [N][N];
  logic [7:0]  ah  [N][N];
  logic [7:0]  bv  [N][N];
  logic [7:0]  m_ai, m_bi;

  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (c == 0) m_ai = pe_a[r*8 +: 8];
        else        m_ai = ah[r][c-1];
        if (r == 0) m_bi = pe_b[c*8 +: 8];
        else        m_bi = bv[r-1][c];
        if (rst) begin
          acc[r][c] <= '0;
          ah[r][c]  <= '0;
          bv[r][c]  <= '0;
        end else begin
          ah[r][c]  <= m_ai;
          bv[r][c]  <= m_bi;
          acc[r][c] <= pe_clear ? 16'h0000 : acc[r][c] + mulq(m_ai, m_bi);
        end
      end
    end
  end

  always_comb begin
    pe_c = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        pe_c[(r*N+c)*16 +: 16] = acc[r][c];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},      32'(busy), 32'd0);
    check({tag, " done"},      32'(done), 32'd0);
    check({tag, " pe_clear"},  32'(pe_clear), 32'd0);
    check({tag, " handshake"}, 32'({bus.in_ready, bus.res_valid, bus.res_last}), 32'd0);
    check({tag, " pe_edges"},  32'({pe_a, pe_b}), 32'd0);
    check({tag, " res_fields"}, 32'({bus.res_data, bus.res_row, bus.res_col}), 32'd0);
  endtask

  task automatic fill_const(input int k, input logic [N*8-1:0] a, input logic [N*8-1:0] b);
    stim_a.delete();
    stim_b.delete();
    for (int i = 0; i < k; i++) begin
      stim_a.push_back(a);
      stim_b.push_back(b);
    end
  endtask

  task automatic run_job(input int k, input int vpct, input int gap_at, input int gap_len,
                         input int rdy_stall, input bit rnd_rdy, input bit chk_lat);
    int cyc, sent, gaps, extra_rdy, unstable, early_done, w, nst;
    logic v;
    logic [15:0]   h_d;
    logic [RW-1:0] h_r, h_c;
    logic          h_l;
    acc_a.delete();
    acc_b.delete();
    cyc = 0; sent = 0; gaps = 0; extra_rdy = 0; unstable = 0; early_done = 0;
    stall_cnt = 0;
    start = 1'b1;
    k_len = KW'(k);
    tick(); cyc++;
    start = 1'b0;
    check("clear_pulse", 32'(pe_clear), 32'd1);
    check("clear_edges_zero", 32'({pe_a, pe_b}), 32'd0);
    check("busy_in_job", 32'(busy), 32'd1);
    while (sent < k && cyc < 2000) begin
      if (sent == gap_at && gaps < gap_len) begin
        v = 1'b0;
        if (bus.in_ready) gaps++;
      end else begin
        v = (int'($urandom_range(99)) < vpct);
      end
      bus.in_valid = v;
      bus.in_a     = stim_a[sent];
      bus.in_b     = stim_b[sent];
      start        = 1'($urandom_range(1));
      k_len        = KW'($urandom);
      if (bus.in_ready && v) begin
        acc_a.push_back(stim_a[sent]);
        acc_b.push_back(stim_b[sent]);
        sent++;
      end else if (bus.in_ready) begin
        stall_cnt++;
      end
      tick(); cyc++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    k_len = '0;
    check("stream_accepts", 32'(sent), 32'(k));
    while (!bus.res_valid && cyc < 2200) begin
      if (bus.in_ready) extra_rdy++;
      tick(); cyc++;
    end
    check("no_ready_outside_stream", 32'(extra_rdy), 32'd0);
    check("res_valid_seen", 32'(bus.res_valid), 32'd1);
    if (chk_lat) check("first_result_latency", 32'(cyc), 32'(k + 2*N + 2));
    for (int i = 0; i < NR; i++) begin
      w = 0;
      while (!bus.res_valid && w < 20) begin tick(); w++; end
      h_d = bus.res_data; h_r = bus.res_row; h_c = bus.res_col; h_l = bus.res_last;
      nst = rdy_stall + (rnd_rdy ? int'($urandom_range(2)) : 0);
      bus.res_ready = 1'b0;
      for (int s = 0; s < nst; s++) begin
        tick();
        if (bus.res_valid !== 1'b1 || bus.res_data !== h_d || bus.res_row !== h_r ||
            bus.res_col !== h_c || bus.res_last !== h_l) unstable++;
        if (done) early_done++;
      end
      got[i] = bus.res_data;
      check("res_data", 32'(bus.res_data), 32'(ref_c(i / N, i % N)));
      check("res_row",  32'(bus.res_row),  32'(i / N));
      check("res_col",  32'(bus.res_col),  32'(i % N));
      check("res_last", 32'(bus.res_last), 32'(i == NR - 1));
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      if (i < NR - 1 && done) early_done++;
    end
    check("stall_stable", 32'(unstable), 32'd0);
    check("no_early_done", 32'(early_done), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("idle_after_done", 32'({busy, bus.res_valid}), 32'd0);
    jobs_done++;
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
`ifdef FP8_SCHED_PERF_EN
    check("perf_stall", 32'(perf_stall), 32'(stall_cnt));
    check("perf_jobs",  32'(perf_jobs),  32'(jobs_done));
`endif
  endtask

  typedef struct {
    int             k;
    logic [N*8-1:0] a;
    logic [N*8-1:0] b;
    logic [15:0]    exp [NR];
  } vec_t;

  vec_t tv [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    pool = '{8'h00, 8'h38, 8'h40, 8'hB8, 8'h30, 8'h3C, 8'hC0};
    tv[0] = '{3,   16'h3838, 16'h3838, '{16'h0180, 16'h0180, 16'h0180, 16'h0180}};
    tv[1] = '{2,   16'hB840, 16'h3838, '{16'h0200, 16'h0200, 16'hFF00, 16'hFF00}};
    tv[2] = '{0,   16'h3838, 16'h3838, '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    tv[3] = '{1,   16'h3838, 16'h3838, '{16'h0080, 16'h0080, 16'h0080, 16'h0080}};
    tv[4] = '{4,   16'h3C30, 16'hC040, '{16'h0200, 16'hFE00, 16'h0600, 16'hFA00}};
    tv[5] = '{255, 16'h3838, 16'h3838, '{16'h7F80, 16'h7F80, 16'h7F80, 16'h7F80}};

    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.res_ready = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) begin
      fill_const(tv[t].k, tv[t].a, tv[t].b);
      run_job(tv[t].k, 100, -1, 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < NR; i++) check($sformatf("table%0d_res%0d", t, i), 32'(got[i]), 32'(tv[t].exp[i]));
    end

    // Five idle cycles mid-stream must not disturb wavefront alignment.
    fill_const(3, 16'h3838, 16'h3838);
    run_job(3, 100, 1, 5, 0, 1'b0, 1'b0);
    for (int i = 0; i < NR; i++) check($sformatf("gap_res%0d", i), 32'(got[i]), 32'h0180);
`ifdef FP8_SCHED_PERF_EN
    check("gap_perf_stall_5", 32'(perf_stall), 32'd5);
`endif

    fill_const(2, 16'hB840, 16'h3838);
    run_job(2, 100, -1, 0, 3, 1'b0, 1'b1);

    // Reset in the middle of DRAIN abandons the job silently.
    fill_const(3, 16'h3838, 16'h3838);
    start = 1'b1; k_len = 8'd3;
    tick();
    start = 1'b0;
    tick();
    bus.in_valid = 1'b1; bus.in_a = 16'h3838; bus.in_b = 16'h3838;
    tick(); tick(); tick();
    bus.in_valid = 1'b0;
    tick();
    check("drain_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check_idle_outputs("mid_drain_reset");
    rst = 1'b0;
    jobs_done = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) bad++;
      tick();
    end
    check("no_done_after_reset", 32'(bad), 32'd0);
    fill_const(1, 16'h3838, 16'h3838);
    run_job(1, 100, -1, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < NR; i++) check($sformatf("post_reset_res%0d", i), 32'(got[i]), 32'h0080);

    for (int j = 0; j < 8; j++) begin
      int k;
      k = int'($urandom_range(1, 7));
      stim_a.delete();
      stim_b.delete();
      for (int s = 0; s < k; s++) begin
        stim_a.push_back({pool[$urandom_range(6)], pool[$urandom_range(6)]});
        stim_b.push_back({pool[$urandom_range(6)], pool[$urandom_range(6)]});
      end
      run_job(k, 70, -1, 0, 0, 1'b1, 1'b0);
      repeat ($urandom_range(2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
